sram_port_arbiter: RTL

Round-robin arbiter and access sequencer that shares the single asynchronous 16-bit SRAM between NUM_PORTS request queues inside the Typhoon GPU. It replaces direct per-queue pin driving: each queue presents a level request (read or write) with address and data, and the arbiter grants one port at a time. It drives the SRAM pins through a fixed three-cycle access sequence and returns a one-cycle acknowledge with read data.

---
 rtl/sram_port_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Round-robin arbiter and access sequencer sharing one asynchronous SRAM
// between NUM_PORTS request queues. A granted access runs IDLE -> ACCESS ->
// FINISH, with the acknowledge pulsed in FINISH and the round-robin pointer
// advanced past the served port.
//
// Optional feature macro: SRAM_ARB_TURNAROUND_EN
//   When defined, a write granted directly after a completed read passes
//   through one TURN cycle (strobes high, DQ released) before ACCESS.
//
// Ports:
//   SRAM_CLK       access clock, all state changes on the rising edge
//   RESET_N        synchronous active-low reset
//   QueueReadReq   per-port level read request, held until Ack
//   QueueWriteReq  per-port level write request, held until Ack (wins over read)
//   AddressToSRAM  per-port address, packed port-major (port p at [p*ADDR_W +: ADDR_W])
//   DataToSRAM     per-port write data, packed port-major
//   Ack            one-cycle completion pulse, one-hot or zero
//   DataFromSRAM   read data, valid in the Ack cycle, held until the next read
//   Busy           high whenever the sequencer is not idle
//   SRAM_ADDR      SRAM address, holds its last value between accesses
//   SRAM_DQ        SRAM data bus, driven only during write ACCESS/FINISH
//   SRAM_*_N       active-low SRAM strobes

module sram_port_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                          SRAM_CLK,
    input  logic                          RESET_N,
    input  logic [NUM_PORTS-1:0]          QueueReadReq,
    input  logic [NUM_PORTS-1:0]          QueueWriteReq,
    input  logic [NUM_PORTS*ADDR_W-1:0]   AddressToSRAM,
    input  logic [NUM_PORTS*DATA_W-1:0]   DataToSRAM,
    output logic [NUM_PORTS-1:0]          Ack,
    output logic [DATA_W-1:0]             DataFromSRAM,
    output logic                          Busy,
    output logic [ADDR_W-1:0]             SRAM_ADDR,
    inout  wire  [DATA_W-1:0]             SRAM_DQ,
    output logic                          SRAM_CE_N,
    output logic                          SRAM_OE_N,
    output logic                          SRAM_WE_N,
    output logic                          SRAM_UB_N,
    output logic                          SRAM_LB_N
);

    localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned SumW = PtrW + 1;
    localparam logic [SumW-1:0] NumPortsS = SumW'(NUM_PORTS);
    localparam logic [PtrW-1:0] LastPort  = PtrW'(NUM_PORTS - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;
`ifdef SRAM_ARB_TURNAROUND_EN
    localparam logic [1:0] StTurn   = 2'd3;
`endif

    logic [1:0]        state_q, state_d;
    logic [PtrW-1:0]   port_q, port_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
`ifdef SRAM_ARB_TURNAROUND_EN
    logic              last_write_q, last_write_d;
`endif

    logic [NUM_PORTS-1:0] req;
    logic                 grant_found;
    logic [PtrW-1:0]      grant_idx;
    logic [SumW-1:0]      cand;
    logic                 dq_oe;

    assign req = QueueReadReq | QueueWriteReq;

    // First requesting port at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, rr_ptr_q} + SumW'(i);
            if (cand >= NumPortsS) begin
                cand = cand - NumPortsS;
            end
            if (!grant_found && req[cand[PtrW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PtrW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rr_ptr_d = rr_ptr_q;
`ifdef SRAM_ARB_TURNAROUND_EN
        last_write_d = last_write_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    port_d  = grant_idx;
                    // Write wins; a simultaneous read stays pending for a later grant.
                    wr_d    = QueueWriteReq[grant_idx];
                    addr_d  = AddressToSRAM[32'(grant_idx) * ADDR_W +: ADDR_W];
                    wdata_d = DataToSRAM[32'(grant_idx) * DATA_W +: DATA_W];
`ifdef SRAM_ARB_TURNAROUND_EN
                    state_d = (QueueWriteReq[grant_idx] && !last_write_q) ? StTurn
                                                                          : StAccess;
`else
                    state_d = StAccess;
`endif
                end
            end
`ifdef SRAM_ARB_TURNAROUND_EN
            StTurn: begin
                state_d = StAccess;
            end
`endif
            StAccess: begin
                // OE_N has been low for the whole cycle, so the bus is settled here.
                if (!wr_q) begin
                    rdata_d = SRAM_DQ;
                end
                state_d = StFinish;
            end
            StFinish: begin
                rr_ptr_d = (port_q == LastPort) ? '0 : port_q + 1'b1;
`ifdef SRAM_ARB_TURNAROUND_EN
                last_write_d = wr_q;
`endif
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge SRAM_CLK) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            port_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rr_ptr_q <= '0;
`ifdef SRAM_ARB_TURNAROUND_EN
            last_write_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef SRAM_ARB_TURNAROUND_EN
            last_write_q <= last_write_d;
`endif
        end
    end

    // Strobes decoded from the registered state; CE/UB/LB stay low through
    // FINISH so write data gets its hold time after WE_N rises.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        Ack       = '0;
        case (state_q)
            StAccess: begin
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (wr_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            StFinish: begin
                SRAM_CE_N   = 1'b0;
                SRAM_UB_N   = 1'b0;
                SRAM_LB_N   = 1'b0;
                dq_oe       = wr_q;
                Ack[port_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign SRAM_DQ      = dq_oe ? wdata_q : {DATA_W{1'bz}};
    assign SRAM_ADDR    = addr_q;
    assign DataFromSRAM = rdata_q;
    assign Busy         = (state_q != StIdle);

endmodule
